delay_timer: RTL
================

# delay_timer

Parametrised, programmable delay timer: the next generation of the fixed one-second delay counter used by the project's control FSMs. A load pulse selects a built-in default or a runtime count, and an optional prescaler divides the count rate. The timer runs one-shot or auto-reloading periodic, and pauses while its enable is low. It sits between the control FSM, which drives load and enable, and any datapath needing timed pacing (blinking, animation frames, game ticks).

## Interface
- `CNT_W`, 29: counter width in bits.
- `DEFAULT_COUNT`, 50000000: count loaded when `load_sel`=0 (1 s at 50 MHz with `PRESCALE`=1). Must fit in `CNT_W`.
- `PRESCALE`, 1: enabled clock cycles per count tick, ≥1.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ld_delay` in 1: load pulse; latches reload value, clears done, arms timer.
- `load_sel` in 1: 0 = load `DEFAULT_COUNT`, 1 = load `load_value`.
- `load_value` in `CNT_W`: runtime count, sampled only when `ld_delay`=1.
- `periodic` in 1: 0 = one-shot, 1 = auto-reload; sampled with `ld_delay`.
- `delayEN` in 1: count enable; low freezes counter and prescaler.
- `delay_done` out 1: sticky expiry flag.
- `delay_pulse` out 1: one-cycle strobe per expiry.
- `busy` out 1: high in ARMED.
- `count` out `CNT_W`: current remaining count.

## Operation
- States: IDLE, ARMED, DONE.
  - Reset → IDLE.
  - `ld_delay` from any state → ARMED.
  - ARMED, one-shot expiry → DONE.
  - ARMED, periodic expiry → ARMED.
  - DONE holds until `ld_delay` or `reset`.
- Load:
  - `count` ← selected value, `reload` ← same value, mode latched.
  - Prescaler cleared; `delay_done` ← 0; `delay_pulse` ← 0.
- Tick: in ARMED with `delayEN`=1, the prescaler counts 0..`PRESCALE`-1; a tick occurs on the cycle it equals `PRESCALE`-1, then it wraps to 0.
- On tick with `count`≠0: `count` ← `count`-1.
- On tick with `count`=0 (expiry):
  - `delay_pulse` ← 1 for one cycle; `delay_done` ← 1.
  - One-shot: `count` stays 0.
  - Periodic: `count` ← `reload`; prescaler restarts from 0.
- A loaded value N expires after N+1 ticks, i.e. (N+1)·`PRESCALE` enabled cycles. N=0 expires on the first tick.
- `delayEN` in IDLE or DONE is ignored; counter and prescaler hold.
- Simultaneous events:
  - `ld_delay` and `delayEN` in the same cycle: load wins, no tick counted.
  - `reset` overrides everything.
- `load_value` wider than the counter is impossible (same width). `DEFAULT_COUNT` exceeding `CNT_W` is an elaboration error.
- Reset values: state IDLE, `count` 0, `reload` 0, prescaler 0, `delay_done` 0, `delay_pulse` 0, `busy` 0.

## Timing
- All outputs registered. No combinational path from inputs to outputs.
- `ld_delay` high at edge k: `count`=N and `busy`=1 visible after edge k.
- With `PRESCALE`=1 and `delayEN` held high from the cycle after load, `delay_pulse`/`delay_done` rise after edge k+N+1.
- `delay_pulse` falls on the next edge unless another expiry occurs. This is only possible in periodic mode with N=0 and `PRESCALE`=1, where the pulse stays high continuously.
- `reset` mid-count: all outputs return to reset values after that edge. The timer does not restart until a new `ld_delay`.
- `delayEN` drop mid-prescale: prescaler phase is preserved. Resuming continues the same partial tick.

## Structure
- Shared package `delay_pkg`:
  - State enum (IDLE/ARMED/DONE).
  - `DEFAULT_COUNT_1S` = 50000000 and `CLK_HZ` = 50000000 constants for reuse by other timing users.
- One sub-module, `tick_prescaler` (parameter `PRESCALE`):
  - Inputs: `clk`, `reset`, `clear`, `en`.
  - Output: `tick`.
  - For `PRESCALE`=1, `tick` = `en`. Prescaler width is $clog2(`PRESCALE`), minimum 1.
- Top level holds the FSM, count/reload registers and output registers.

## Test plan
- Reset, then load with `load_sel`=1, `load_value`=3, `PRESCALE`=1, `delayEN`=1 continuously → `count` 3,2,1,0. `delay_done` and `delay_pulse` rise after the 4th enabled edge. `delay_pulse` is high exactly 1 cycle, `busy` falls, `delay_done` stays high.
- Periodic, `load_value`=2 → `delay_pulse` every 3 cycles for ≥4 periods, `count` reloads to 2, `busy` stays 1.
- `PRESCALE`=4, `load_value`=1, `delayEN` dropped for 5 cycles mid-prescale → expiry after exactly 8 enabled cycles. Count and prescaler are frozen during the gap.
- `ld_delay` asserted with `delayEN`=1 while ARMED at `count`=5, new value 7 → `count`=7 next cycle (no decrement), `delay_done`=0.
- `load_value`=0 one-shot → expiry on the first enabled tick. `load_sel`=0 → `count` = 50000000 after load.
- `reset` asserted at `count`=2 → all outputs 0 next cycle. `delayEN` afterwards causes no activity until `ld_delay`.

Source files
------------

// File: rtl/delay_pkg.sv
// rtl/delay_pkg.sv - shared timer state encoding and timing constants
package delay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam longint CLK_HZ           = 50000000;
    localparam longint DEFAULT_COUNT_1S = 50000000;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides enabled cycles into count ticks
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, phase to 0
//   clear - synchronous phase restart (timer load)
//   en    - advance the phase this cycle; low holds the phase
//   tick  - high on the enabled cycle where the phase is PRESCALE-1
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] phase;

    // With PRESCALE=1 the phase never leaves 0, so tick reduces to en.
    assign tick = en && (phase == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == LAST) ? '0 : phase + W'(1);
        end
    end

endmodule

// File: rtl/delay_timer.sv
// rtl/delay_timer.sv - programmable one-shot/periodic delay timer
// Ports:
//   clk         - rising-edge clock
//   reset       - synchronous active-high reset
//   ld_delay    - load pulse: latch count/reload/mode, clear done, arm
//   load_sel    - 0 loads DEFAULT_COUNT, 1 loads load_value
//   load_value  - runtime count
//   periodic    - 1 auto-reloads on expiry, 0 stops in DONE
//   delayEN     - count enable, freezes counter and prescaler when low
//   delay_done  - sticky expiry flag
//   delay_pulse - one-cycle strobe per expiry
//   busy        - high while armed
//   count       - remaining count
module delay_timer
    import delay_pkg::*;
#(
    parameter int     CNT_W         = 29,
    parameter longint DEFAULT_COUNT = DEFAULT_COUNT_1S,
    parameter int     PRESCALE      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_delay,
    input  logic             load_sel,
    input  logic [CNT_W-1:0] load_value,
    input  logic             periodic,
    input  logic             delayEN,
    output logic             delay_done,
    output logic             delay_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    if (CNT_W < 63 && (DEFAULT_COUNT < 0 || DEFAULT_COUNT >= (longint'(1) << CNT_W))) begin : g_bad_default
        $error("delay_timer: DEFAULT_COUNT does not fit in CNT_W bits");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("delay_timer: PRESCALE must be at least 1");
    end

    localparam logic [CNT_W-1:0] DEFAULT_VAL = CNT_W'(DEFAULT_COUNT);

    state_t           state;
    logic [CNT_W-1:0] reload;
    logic             periodic_q;
    logic             tick;

    // A load in the same cycle as delayEN must not count a tick, so the
    // prescaler is held off and restarted by ld_delay.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (ld_delay),
        .en    ((state == ST_ARMED) && delayEN && !ld_delay),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            reload      <= '0;
            periodic_q  <= 1'b0;
            delay_done  <= 1'b0;
            delay_pulse <= 1'b0;
            busy        <= 1'b0;
        end else if (ld_delay) begin
            state       <= ST_ARMED;
            count       <= load_sel ? load_value : DEFAULT_VAL;
            reload      <= load_sel ? load_value : DEFAULT_VAL;
            periodic_q  <= periodic;
            delay_done  <= 1'b0;
            delay_pulse <= 1'b0;
            busy        <= 1'b1;
        end else begin
            delay_pulse <= 1'b0;
            if (state == ST_ARMED && tick) begin
                if (count != '0) begin
                    count <= count - CNT_W'(1);
                end else begin
                    // Expiry happens on the tick after count reaches 0,
                    // giving N+1 ticks for a loaded value N.
                    delay_pulse <= 1'b1;
                    delay_done  <= 1'b1;
                    if (periodic_q) begin
                        count <= reload;
                    end else begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
